axis_pkt_rr_arb: RTL and testbench

Packet-level round-robin arbiter that shares one AXI-Stream output bus among NUM_PORTS AXI-Stream requesters. A grant is held for a whole packet and switches only after the last beat (tlast), so packets are never interleaved. Per-port enable masks and per-port packet counters let a control plane schedule and observe the shared stream. It sits in front of any single-consumer stream resource (DMA engine, framer, crossbar leg).

---
 rtl/axis_arb_pkg.sv | 41 ++++
 rtl/axis_rr_pick.sv | 57 +++++
 rtl/axis_pkt_rr_arb.sv | 127 ++++++++++++
 tb/tb_axis_pkt_rr_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the packet-level stream arbiters.
//   arb_state_t : arbiter FSM state (ST_IDLE = no grant, ST_PASS = packet held)
//   rr_next()   : behavioural round-robin pick over up to RR_MAX_PORTS
//                 requesters, kept here so weighted variants can reuse it.
// ---------------------------------------------------------------------------
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } arb_state_t;

    localparam int unsigned RR_MAX_PORTS = 16;
    localparam int unsigned RR_IDX_W     = 4;

    // First set bit of req scanning upward from (last+1) mod n, wrapping.
    // Returns last when req is empty; callers gate with |req.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX_PORTS-1:0] req,
        input logic [RR_IDX_W-1:0]     last,
        input int unsigned             n
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = last;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= RR_MAX_PORTS; k++) begin
            idx = (32'(last) + k) % n;
            if ((k <= n) && !found && req[idx[RR_IDX_W-1:0]]) begin
                pick  = idx[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// ---------------------------------------------------------------------------
// axis_rr_pick
// Combinational round-robin selector: rotate req so that port (last+1) sits
// at bit 0, priority-encode the lowest set bit, then rotate the index back.
//   req        in  NUM_PORTS  request vector
//   last       in  SEL_W      most recently granted port (lowest priority)
//   pick       out SEL_W      selected port (meaningful when pick_valid)
//   pick_valid out 1          at least one request present
// ---------------------------------------------------------------------------
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     last,
    output logic [SEL_W-1:0]     pick,
    output logic                 pick_valid
);

    logic [NUM_PORTS-1:0] rot;
    int                   start;
    int                   src;
    int                   off;
    int                   sum;
    logic                 found;

    always_comb begin
        rot   = '0;
        src   = 0;
        off   = 0;
        sum   = 0;
        found = 1'b0;
        // Starting point wraps explicitly so non-power-of-two port counts work.
        start = (int'(last) >= NUM_PORTS - 1) ? 0 : int'(last) + 1;

        for (int i = 0; i < NUM_PORTS; i++) begin
            src = start + i;
            if (src >= NUM_PORTS) src = src - NUM_PORTS;
            rot[i] = req[src[SEL_W-1:0]];
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && rot[i]) begin
                off   = i;
                found = 1'b1;
            end
        end

        sum = start + off;
        if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
        pick       = sum[SEL_W-1:0];
        pick_valid = |req;
    end

endmodule

// File: rtl/axis_pkt_rr_arb.sv
// ---------------------------------------------------------------------------
// axis_pkt_rr_arb
// Packet-level round-robin arbiter: NUM_PORTS AXI-Stream inputs share one
// output. A grant is held until the tlast beat transfers, so packets never
// interleave. Per-port enables gate arbitration; per-port counters track
// completed packets.
//   clk, rst   clock, synchronous active-high reset
//   s_tdata    in  NUM_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W]
//   s_tlast    in  NUM_PORTS         per-port last flags
//   s_tvalid   in  NUM_PORTS         per-port valids (request when enabled)
//   s_tready   out NUM_PORTS         per-port readies
//   m_tdata/m_tlast/m_tvalid out, m_tready in   shared output stream
//   m_tsel     out SEL_W             granted port (last grant while idle)
//   port_en    in  NUM_PORTS         arbitration enable, used at decisions only
//   busy       out 1                 packet in flight (ST_PASS)
//   pkt_count  out NUM_PORTS*COUNT_W completed packets, port i at
//                                    [i*COUNT_W +: COUNT_W], wrapping
//
// Handshake: a beat moves on a side when valid && ready at a rising clk.
// The granted port's tready equals m_tready; every other tready is 0; the
// arbiter never drops a granted port's tready mid-packet except via m_tready.
// ---------------------------------------------------------------------------
module axis_pkt_rr_arb
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int COUNT_W   = 32,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*DATA_W-1:0]    s_tdata,
    input  logic [NUM_PORTS-1:0]           s_tlast,
    input  logic [NUM_PORTS-1:0]           s_tvalid,
    output logic [NUM_PORTS-1:0]           s_tready,
    output logic [DATA_W-1:0]              m_tdata,
    output logic                           m_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [SEL_W-1:0]               m_tsel,
    input  logic [NUM_PORTS-1:0]           port_en,
    output logic                           busy,
    output logic [NUM_PORTS*COUNT_W-1:0]   pkt_count
);

    arb_state_t           state;
    // The held grant and the round-robin "last grant" are always equal, so a
    // single register serves both roles.
    logic [SEL_W-1:0]     grant;
    logic [COUNT_W-1:0]   cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] grant_oh;
    logic [NUM_PORTS-1:0] pick_req;
    logic [SEL_W-1:0]     pick;
    logic                 pick_valid;
    logic                 in_pass;
    logic                 xfer;
    logic                 last_xfer;

    assign req     = s_tvalid & port_en;
    assign in_pass = (state == ST_PASS);

    always_comb begin
        grant_oh        = '0;
        grant_oh[grant] = 1'b1;
    end

    // In PASS the only decision point is the completing tlast beat, whose
    // valid belongs to the current grant, so that port is masked out.
    assign pick_req = in_pass ? (req & ~grant_oh) : req;

    axis_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_W     (SEL_W)
    ) u_pick (
        .req        (pick_req),
        .last       (grant),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    // Zero-latency datapath; rst forces the handshakes low so no beat is
    // consumed during a reset cycle.
    always_comb begin
        m_tdata  = s_tdata[grant*DATA_W +: DATA_W];
        m_tlast  = s_tlast[grant];
        m_tvalid = in_pass && !rst && s_tvalid[grant];
        s_tready = (in_pass && !rst && m_tready) ? grant_oh : '0;
        m_tsel   = grant;
        busy     = in_pass;
    end

    assign xfer      = m_tvalid & m_tready;
    assign last_xfer = xfer & m_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= SEL_W'(NUM_PORTS - 1);
            for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick;
                        state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (last_xfer) begin
                        cnt[grant] <= cnt[grant] + COUNT_W'(1);
                        if (pick_valid) grant <= pick;
                        else            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
        assign pkt_count[gi*COUNT_W +: COUNT_W] = cnt[gi];
    end

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_rr_arb
// Directed bench for axis_pkt_rr_arb (4 ports, 16-bit data, 4-bit counters).
// Each source is a small packet queue; beat data is {port, pkt seq, beat}.
// Expected grants, data and counter values below are worked out by hand.
// ---------------------------------------------------------------------------
module tb_axis_pkt_rr_arb;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [SW-1:0]     m_tsel;
    logic [NP-1:0]     port_en;
    logic              busy;
    logic [NP*CW-1:0]  pkt_count;

    // clock / reset
    always #5 clk = ~clk;

    axis_pkt_rr_arb #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .COUNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tsel    (m_tsel),
        .port_en   (port_en),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    int           vectors     = 0;
    int           miscompares = 0;

    // source model state
    int           npk  [NP];
    int           rem  [NP];
    int           plen [NP];
    logic [3:0]   seq  [NP];
    logic [7:0]   beat [NP];
    logic [NP-1:0] fired;

    // control values applied at the next step
    logic          p_rdy;
    logic          p_rst;
    logic [NP-1:0] p_en;

    logic [15:0]   t2_d [12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            s_tvalid[i]          = (npk[i] > 0);
            s_tlast[i]           = (rem[i] == 1);
            s_tdata[i*DW +: DW]  = {4'(i), seq[i], beat[i]};
        end
    endtask

    // Advance one clock: retire beats accepted at the edge, apply controls,
    // present the sources, then let combinational outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (fired[i]) begin
                beat[i]++;
                rem[i]--;
                if (rem[i] == 0) begin
                    npk[i]--;
                    seq[i]++;
                    beat[i] = 8'h00;
                    rem[i]  = plen[i];
                end
            end
        end
        rst      = p_rst;
        m_tready = p_rdy;
        port_en  = p_en;
        drive();
        #1;
        fired = s_tvalid & s_tready;
    endtask

    task automatic add_pkts(input int p, input int n, input int len);
        if (npk[p] == 0) rem[p] = len;
        plen[p] = len;
        npk[p]  = npk[p] + n;
    endtask

    task automatic expect_beat(input string tag, input logic [SW-1:0] sel,
                               input logic [DW-1:0] data, input logic last);
        logic [NP-1:0] exp_rdy;
        exp_rdy = p_rdy ? (NP'(1) << sel) : '0;
        chk({tag, ".tvalid"}, 32'(m_tvalid), 32'd1);
        chk({tag, ".tsel"},   32'(m_tsel),   32'(sel));
        chk({tag, ".tdata"},  32'(m_tdata),  32'(data));
        chk({tag, ".tlast"},  32'(m_tlast),  32'(last));
        chk({tag, ".tready"}, 32'(s_tready), 32'(exp_rdy));
    endtask

    task automatic expect_idle(input string tag, input logic [SW-1:0] sel);
        chk({tag, ".tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, ".busy"},   32'(busy),     32'd0);
        chk({tag, ".tready"}, 32'(s_tready), 32'd0);
        chk({tag, ".tsel"},   32'(m_tsel),   32'(sel));
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            npk[i] = 0; rem[i] = 0; plen[i] = 1; seq[i] = 4'h0; beat[i] = 8'h00;
        end
        fired    = '0;
        p_rdy    = 1'b1;
        p_rst    = 1'b1;
        p_en     = 4'b1111;
        rst      = 1'b1;
        m_tready = 1'b1;
        port_en  = 4'b1111;
        drive();
        t2_d = '{16'h3000, 16'h0100, 16'h1000, 16'h2100,
                 16'h3100, 16'h0200, 16'h1100, 16'h2200,
                 16'h3200, 16'h0300, 16'h1200, 16'h2300};

        // reset state
        step(); step();
        expect_idle("rst", 2'd3);
        chk("rst.count", 32'(pkt_count), 32'h0);
        p_rst = 1'b0;

        // ports 0 and 2, 3-beat packets, back to back
        add_pkts(0, 1, 3);
        add_pkts(2, 1, 3);
        step(); expect_idle("t1.req", 2'd3);
        step(); expect_beat("t1.p0b0", 2'd0, 16'h0000, 1'b0);
        step(); expect_beat("t1.p0b1", 2'd0, 16'h0001, 1'b0);
        step(); expect_beat("t1.p0b2", 2'd0, 16'h0002, 1'b1);
        step(); expect_beat("t1.p2b0", 2'd2, 16'h2000, 1'b0);
        step(); expect_beat("t1.p2b1", 2'd2, 16'h2001, 1'b0);
        step(); expect_beat("t1.p2b2", 2'd2, 16'h2002, 1'b1);
        step(); expect_idle("t1.end", 2'd2);
        chk("t1.count", 32'(pkt_count), 32'h0101);

        // all ports, single-beat packets, one transfer per cycle
        for (int i = 0; i < NP; i++) add_pkts(i, 3, 1);
        step(); expect_idle("t2.req", 2'd2);
        for (int k = 0; k < 12; k++) begin
            step();
            expect_beat($sformatf("t2.k%0d", k), t2_d[k][13:12], t2_d[k], 1'b1);
        end
        step(); expect_idle("t2.end", 2'd2);
        chk("t2.count", 32'(pkt_count), 32'h3434);

        // port 1 packet under backpressure, port 3 waits for its tlast
        add_pkts(1, 1, 3);
        step(); expect_idle("t3.req", 2'd2);
        add_pkts(3, 1, 2);
        step();             expect_beat("t3.b0",    2'd1, 16'h1300, 1'b0);
        p_rdy = 1'b0; step(); expect_beat("t3.b1s",  2'd1, 16'h1301, 1'b0);
        p_rdy = 1'b1; step(); expect_beat("t3.b1",   2'd1, 16'h1301, 1'b0);
        p_rdy = 1'b0; step(); expect_beat("t3.b2s",  2'd1, 16'h1302, 1'b1);
        p_rdy = 1'b1; step(); expect_beat("t3.b2",   2'd1, 16'h1302, 1'b1);
        step();             expect_beat("t3.p3b0", 2'd3, 16'h3300, 1'b0);
        step();             expect_beat("t3.p3b1", 2'd3, 16'h3301, 1'b1);
        step(); expect_idle("t3.end", 2'd3);
        chk("t3.count", 32'(pkt_count), 32'h4444);

        // port 2 masked; port 0 disabled mid-packet
        for (int i = 0; i < NP; i++) add_pkts(i, 2, 2);
        p_en = 4'b1011;
        step(); expect_idle("t4.req", 2'd3);
        step(); expect_beat("t4.p0b0", 2'd0, 16'h0400, 1'b0);
        p_en = 4'b1010;
        step(); expect_beat("t4.p0b1", 2'd0, 16'h0401, 1'b1);
        step(); expect_beat("t4.p1a0", 2'd1, 16'h1400, 1'b0);
        step(); expect_beat("t4.p1a1", 2'd1, 16'h1401, 1'b1);
        step(); expect_beat("t4.p3a0", 2'd3, 16'h3400, 1'b0);
        step(); expect_beat("t4.p3a1", 2'd3, 16'h3401, 1'b1);
        step(); expect_beat("t4.p1b0", 2'd1, 16'h1500, 1'b0);
        step(); expect_beat("t4.p1b1", 2'd1, 16'h1501, 1'b1);
        step(); expect_beat("t4.p3b0", 2'd3, 16'h3500, 1'b0);
        step(); expect_beat("t4.p3b1", 2'd3, 16'h3501, 1'b1);
        step(); expect_idle("t4.mask", 2'd3);
        chk("t4.count", 32'(pkt_count), 32'h6465);
        // re-enable; port 2's second packet waits out one idle cycle
        p_en = 4'b1111;
        step(); expect_idle("t4.ren", 2'd3);
        step(); expect_beat("t4.p0c0", 2'd0, 16'h0500, 1'b0);
        step(); expect_beat("t4.p0c1", 2'd0, 16'h0501, 1'b1);
        step(); expect_beat("t4.p2a0", 2'd2, 16'h2400, 1'b0);
        step(); expect_beat("t4.p2a1", 2'd2, 16'h2401, 1'b1);
        step(); expect_idle("t4.gap", 2'd2);
        step(); expect_beat("t4.p2b0", 2'd2, 16'h2500, 1'b0);
        step(); expect_beat("t4.p2b1", 2'd2, 16'h2501, 1'b1);
        step(); expect_idle("t4.end", 2'd2);
        chk("t4.count2", 32'(pkt_count), 32'h6666);

        // reset during beat 2 of a 4-beat packet
        add_pkts(1, 1, 4);
        step(); expect_idle("t5.req", 2'd2);
        step(); expect_beat("t5.b0", 2'd1, 16'h1600, 1'b0);
        add_pkts(0, 1, 1);
        p_rst = 1'b1;
        step();
        chk("t5.rst.tvalid", 32'(m_tvalid), 32'd0);
        chk("t5.rst.tready", 32'(s_tready), 32'd0);
        p_rst = 1'b0;
        step(); expect_idle("t5.post", 2'd3);
        chk("t5.count0", 32'(pkt_count), 32'h0);
        step(); expect_beat("t5.p0",  2'd0, 16'h0600, 1'b1);
        step(); expect_beat("t5.r1",  2'd1, 16'h1601, 1'b0);
        step(); expect_beat("t5.r2",  2'd1, 16'h1602, 1'b0);
        step(); expect_beat("t5.r3",  2'd1, 16'h1603, 1'b1);
        step(); expect_idle("t5.end", 2'd1);
        chk("t5.count", 32'(pkt_count), 32'h0011);

        // counter wrap on port 0 (4-bit counters)
        add_pkts(0, 14, 1);
        repeat (28) step();
        step();
        chk("t6.count15", 32'(pkt_count), 32'h001F);
        add_pkts(0, 1, 1);
        repeat (3) step();
        chk("t6.wrap0", 32'(pkt_count), 32'h0010);
        add_pkts(0, 1, 1);
        repeat (3) step();
        chk("t6.wrap1", 32'(pkt_count), 32'h0011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
